seq_state_monitor: RTL
======================

# seq_state_monitor

Receive-side checker for the 2-bit free-running state sequence (00→01→10→11→00) and its registered wrap pulse produced by the team's Moore sequence generator. It samples the generator's state and pulse outputs every clock and acquires lock after a run of correct transitions. Once locked, it counts wraps and errors, and drops lock with hysteresis. It sits on the consuming side of that interface, next to the generator, as a bring-up and self-check block.

## Interface
- LOCK_COUNT, 4: consecutive good transitions required to lock; range ≥1.
- LOSS_COUNT, 2: consecutive bad transitions that drop lock; range ≥1.
- CNT_W, 16: width of the saturating wrap and error counters.

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous; zeroes wrap_count and err_count only
- in_state  in  2  sampled generator state
- in_pulse  in  1  sampled generator wrap pulse
- locked  out  1  high while mon_state is LOCKED or LOSS
- mon_state  out  2  HUNT=00, SYNC=01, LOCKED=10, LOSS=11
- err  out  1  one-cycle flag per bad transition judged in LOCKED or LOSS
- wrap  out  1  one-cycle flag per good 11→00 transition judged in LOCKED or LOSS
- wrap_count  out  CNT_W  saturating count of wrap events
- err_count  out  CNT_W  saturating count of err events

## Operation
- Internal state: prev_state[1:0], prev_valid, good_cnt, bad_cnt, and FSM state.
- First clock after reset: in_state is captured into prev_state and prev_valid is set. No judgement is made on this clock.
- Each later clock judges one transition:
  - good: in_state == prev_state+1 mod 4, plus the pulse rule when configured.
  - bad: otherwise.
  - prev_state ← in_state on every clock.
- Pulse rule: in_pulse must equal (prev_state == 11). The generator registers its pulse from the old state, so the pulse is high in the same cycle as the 00 that follows 11.
- FSM transitions:
  - HUNT: good → SYNC with good_cnt=1, or straight to LOCKED if LOCK_COUNT==1. Bad → stay in HUNT.
  - SYNC: good → good_cnt+1; on reaching LOCK_COUNT → LOCKED. Bad → HUNT, good_cnt=0.
  - LOCKED: good → stay. Bad → LOSS with bad_cnt=1, or straight to HUNT if LOSS_COUNT==1.
  - LOSS: good → LOCKED, bad_cnt=0. Bad → bad_cnt+1; on reaching LOSS_COUNT → HUNT, good_cnt=0.
- err/wrap qualification uses the FSM state before the update.
- Counters saturate at all-ones and never wrap.
- clear has priority over an increment in the same cycle; the result is 0.
- clear does not affect the FSM, prev_state, or the err/wrap flags.

## Timing
- Reset values: locked=0, mon_state=00, err=0, wrap=0, wrap_count=0, err_count=0, prev_valid=0.
- Reset asserted mid-operation returns to these values immediately (asynchronous). The first clock after release is a capture-only clock.
- Latency: a transition judged at edge k updates every output at edge k. All outputs are registered and visible in the cycle after sampling.
- Minimum time to lock after reset: 1 capture edge + LOCK_COUNT judge edges, i.e. locked high after edge 5 with the defaults.
- err and wrap are mutually exclusive. Each is high for exactly one cycle per event; back-to-back events give back-to-back highs.

## Configuration
- SEQ_MON_PULSE_CHECK_EN defined: the pulse rule is part of the good/bad judgement.
- SEQ_MON_PULSE_CHECK_EN undefined: in_pulse is ignored and the judgement uses the state sequence only. The port remains present.

## Test plan
- Reset, then drive 00,01,10,11,00,… with correct pulses:
  - locked rises after edge 5 and mon_state=10.
  - Each subsequent 11→00 pulses wrap and increments wrap_count; err_count stays 0.
- Locked, then drive 01→11 (skip):
  - err for one cycle, err_count=1, mon_state=11, locked stays 1.
  - The next 11→00 returns mon_state to 10 and pulses wrap.
- Locked, then two consecutive bad transitions:
  - mon_state=00 and locked=0 after the second.
  - A correct sequence relocks after 4 good transitions.
- Correct states but in_pulse held 0 at the 00 after 11:
  - With the macro: err=1 and err_count increments.
  - Without the macro: no err, and wrap still pulses.
- CNT_W=4, 20 wraps while locked: wrap_count holds at 15. Asserting clear in the same cycle as a wrap gives wrap_count=0.
- Assert reset mid-LOCKED: all outputs are 0 immediately, and relock requires capture plus 4 good transitions.

Source files
------------

// File: rtl/seq_state_monitor.sv
// seq_state_monitor
// Receive-side checker for the 2-bit free-running generator sequence
// 00->01->10->11->00 and its registered wrap pulse. It captures one sample
// after reset and then judges one transition per clock. It acquires lock
// after LOCK_COUNT consecutive good transitions and drops lock after
// LOSS_COUNT consecutive bad ones. While tracking, it flags and counts wraps
// and errors in saturating counters.
//
// Optional feature macro: SEQ_MON_PULSE_CHECK_EN
//   defined   -> in_pulse must equal (previous state == 11) for a good judgement
//   undefined -> in_pulse is ignored; only the state sequence is judged

module seq_state_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [1:0]       in_state,
  input  logic             in_pulse,
  output logic             locked,
  output logic [1:0]       mon_state,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int BAD_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10,
    LOSS   = 2'b11
  } mon_state_e;

  mon_state_e        state_q, state_d;
  logic [1:0]        prevState_q;
  logic              prevValid_q;
  logic [GOOD_W-1:0] goodCnt_q, goodCnt_d;
  logic [BAD_W-1:0]  badCnt_q, badCnt_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic [CNT_W-1:0]  wrapCount_q, wrapCount_d;
  logic [CNT_W-1:0]  errCount_q, errCount_d;

  logic [1:0] expectState;
  logic       stateOk;
  logic       pulseOk;
  logic       judge;
  logic       isGood;
  logic       tracking;

  // The successor of the previous sample is the only acceptable next state.
  assign expectState = prevState_q + 2'd1;
  assign stateOk     = (in_state == expectState);

`ifdef SEQ_MON_PULSE_CHECK_EN
  // The generator registers its pulse from the old state, so the pulse
  // accompanies the 00 that follows 11 and must be low everywhere else.
  assign pulseOk = (in_pulse == (prevState_q == 2'b11));
`else
  logic unusedPulse;
  assign unusedPulse = in_pulse;
  assign pulseOk     = 1'b1;
`endif

  // No judgement is made until one sample has been captured after reset.
  assign judge    = prevValid_q;
  assign isGood   = stateOk & pulseOk;
  assign tracking = (state_q == LOCKED) || (state_q == LOSS);

  // State register: FSM, hysteresis counters, sample history and event flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      goodCnt_q   <= '0;
      badCnt_q    <= '0;
      prevState_q <= 2'b00;
      prevValid_q <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      goodCnt_q   <= goodCnt_d;
      badCnt_q    <= badCnt_d;
      prevState_q <= in_state;
      prevValid_q <= 1'b1;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
    end
  end

  // Next-state logic: lock acquisition in HUNT/SYNC, hysteresis in LOCKED/LOSS.
  always_comb begin
    state_d   = state_q;
    goodCnt_d = goodCnt_q;
    badCnt_d  = badCnt_q;
    if (judge) begin
      unique case (state_q)
        HUNT: begin
          if (isGood) begin
            goodCnt_d = GOOD_W'(1);
            state_d   = (LOCK_COUNT == 1) ? LOCKED : SYNC;
          end else begin
            goodCnt_d = '0;
          end
        end
        SYNC: begin
          if (isGood) begin
            goodCnt_d = goodCnt_q + GOOD_W'(1);
            if (goodCnt_d == GOOD_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
            end
          end else begin
            goodCnt_d = '0;
            state_d   = HUNT;
          end
        end
        LOCKED: begin
          if (isGood) begin
            badCnt_d = '0;
          end else if (LOSS_COUNT == 1) begin
            badCnt_d  = '0;
            goodCnt_d = '0;
            state_d   = HUNT;
          end else begin
            badCnt_d = BAD_W'(1);
            state_d  = LOSS;
          end
        end
        LOSS: begin
          if (isGood) begin
            badCnt_d = '0;
            state_d  = LOCKED;
          end else begin
            badCnt_d = badCnt_q + BAD_W'(1);
            if (badCnt_d == BAD_W'(LOSS_COUNT)) begin
              badCnt_d  = '0;
              goodCnt_d = '0;
              state_d   = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output logic: events are qualified by the FSM state before this update.
  always_comb begin
    err_d  = judge & tracking & ~isGood;
    wrap_d = judge & tracking & isGood & (prevState_q == 2'b11);
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_comb begin
    wrapCount_d = wrapCount_q;
    errCount_d  = errCount_q;
    if (clear) begin
      wrapCount_d = '0;
      errCount_d  = '0;
    end else begin
      if (wrap_d && (wrapCount_q != {CNT_W{1'b1}})) begin
        wrapCount_d = wrapCount_q + CNT_W'(1);
      end
      if (err_d && (errCount_q != {CNT_W{1'b1}})) begin
        errCount_d = errCount_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrapCount_q <= '0;
      errCount_q  <= '0;
    end else begin
      wrapCount_q <= wrapCount_d;
      errCount_q  <= errCount_d;
    end
  end

  assign locked     = tracking;
  assign mon_state  = state_q;
  assign err        = err_q;
  assign wrap       = wrap_q;
  assign wrap_count = wrapCount_q;
  assign err_count  = errCount_q;

endmodule
